breath_led_axil_slave: RTL and testbench

// - AXI4-Lite responder for the breath LED IP; the far end of the master VIP in the BD wrapper bench.
// - Holds four 32-bit read/write registers and drives a triangle-wave PWM "breathing" LED from them.
// - Sits inside the breath_led_ip_v1_0 top, between the PS AXI interconnect and the LED pin.

---
 rtl/breath_led_pkg.sv | 31 +++
 rtl/breath_led_pwm.sv | 94 +++++++++
 rtl/breath_led_axil_slave.sv | 134 +++++++++++++
 tb/tb_breath_led_axil_slave.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breath_led_pkg.sv
// Shared definitions for the breath LED AXI4-Lite slave: register map,
// control bit positions, response codes and the FSM state encodings.
package breath_led_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STEP = 2'd1;
  localparam logic [1:0] REG_SCR0 = 2'd2;
  localparam logic [1:0] REG_SCR1 = 2'd3;

  localparam int CTRL_EN_BIT = 0;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACCEPT = 2'd1,
    RD_DATA   = 2'd2
  } rd_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/breath_led_pwm.sv
// Triangle-wave breathing PWM: a free-running frame counter compared against
// a duty value that ramps up and down by STEP once per frame.
module breath_led_pwm
  import breath_led_pkg::*;
#(
  parameter int PWM_PERIOD = 1000,
  parameter int STEP_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [STEP_W-1:0] step,
  output logic              led,
  output logic              dir_state
);

  localparam int CW = $clog2(PWM_PERIOD + 1);
  // Wide enough that duty + step never overflows before the clamp compare.
  localparam int SW = ((CW > STEP_W) ? CW : STEP_W) + 1;
  localparam logic [SW-1:0] PERIOD_EXT = SW'(PWM_PERIOD);

  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] duty;
  logic [CW-1:0] duty_next;
  dir_t          dir;
  dir_t          dir_next;
  logic          frame_wrap;
  logic [SW-1:0] step_eff;
  logic [SW-1:0] duty_ext;

  assign frame_wrap = (frame_cnt == CW'(PWM_PERIOD - 1));
  // A zero step would freeze the ramp, so it behaves as one.
  assign step_eff   = (step == '0) ? SW'(1) : SW'(step);
  assign duty_ext   = SW'(duty);
  assign dir_state  = (dir == DIR_DOWN);

  // Direction/duty state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir  <= DIR_UP;
      duty <= '0;
    end else begin
      dir  <= dir_next;
      duty <= duty_next;
    end
  end

  // Next duty and direction: move only at frame wrap, clamp and turn at the ends.
  always_comb begin
    dir_next  = dir;
    duty_next = duty;
    if (!enable) begin
      dir_next  = DIR_UP;
      duty_next = '0;
    end else if (frame_wrap) begin
      if (dir == DIR_UP) begin
        if (duty_ext + step_eff >= PERIOD_EXT) begin
          duty_next = CW'(PWM_PERIOD);
          dir_next  = DIR_DOWN;
        end else begin
          duty_next = CW'(duty_ext + step_eff);
        end
      end else begin
        if (step_eff >= duty_ext) begin
          duty_next = '0;
          dir_next  = DIR_UP;
        end else begin
          duty_next = CW'(duty_ext - step_eff);
        end
      end
    end
  end

  // Frame counter, held at zero while disabled so re-enable starts a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (!enable || frame_wrap) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CW'(1);
    end
  end

  // Registered LED compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 1'b0;
    end else begin
      led <= enable && (frame_cnt < duty);
    end
  end

endmodule

// File: rtl/breath_led_axil_slave.sv
// AXI4-Lite slave with four 32-bit registers (CTRL, STEP, SCRATCH0/1)
// driving the breathing PWM LED.
//
// Handshake: a channel transfer happens on the rising edge where VALID and
// READY are both high. READY here is a one-cycle pulse raised only after the
// master's VALID is seen; the master must hold VALID and payload until then.
// BVALID/RVALID stay high with stable payload until the matching READY.
module breath_led_axil_slave
  import breath_led_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_PERIOD         = 1000,
  parameter int STEP_W             = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            led_o,
  output logic [1:0]                      dbg_wr_state,
  output logic [1:0]                      dbg_rd_state,
  output logic                            dbg_pwm_dir
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [0:3];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    wr_idx;
  logic [1:0]                    rd_idx;
  logic                          unused_ok;

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = (wr_state == WR_ACCEPT);
  assign S_AXI_WREADY  = (wr_state == WR_ACCEPT);
  assign S_AXI_BVALID  = (wr_state == WR_RESP);
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = (rd_state == RD_ACCEPT);
  assign S_AXI_RVALID  = (rd_state == RD_DATA);
  assign S_AXI_RRESP   = AXI_RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign dbg_wr_state  = wr_state;
  assign dbg_rd_state  = rd_state;

  // Write and read channel state registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Write FSM: accept address and data together, then hold the response.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = WR_ACCEPT;
      WR_ACCEPT: wr_next = WR_RESP;
      WR_RESP:   if (S_AXI_BREADY) wr_next = WR_IDLE;
      default:   wr_next = WR_IDLE;
    endcase
  end

  // Read FSM: one-cycle address accept, then data held until taken.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:   if (S_AXI_ARVALID) rd_next = RD_ACCEPT;
      RD_ACCEPT: rd_next = RD_DATA;
      RD_DATA:   if (S_AXI_RREADY) rd_next = RD_IDLE;
      default:   rd_next = RD_IDLE;
    endcase
  end

  // Register file, byte-lane writes on the address/data accept cycle.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_state == WR_ACCEPT) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) regs[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read data capture; a coincident write lands on the same edge, so the old value is returned.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
    end else if (rd_state == RD_ACCEPT) begin
      rdata_q <= regs[rd_idx];
    end
  end

  breath_led_pwm #(
    .PWM_PERIOD (PWM_PERIOD),
    .STEP_W     (STEP_W)
  ) u_pwm (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .enable    (regs[REG_CTRL][CTRL_EN_BIT]),
    .step      (regs[REG_STEP][STEP_W-1:0]),
    .led       (led_o),
    .dir_state (dbg_pwm_dir)
  );

endmodule

// File: tb/tb_breath_led_axil_slave.sv
// Directed bench for breath_led_axil_slave: register access, byte strobes,
// staggered AW/W, BREADY stall, PWM ramp, enable toggling and mid-read reset.
module tb_breath_led_axil_slave;
  import breath_led_pkg::*;

  localparam int PERIOD = 1000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        led;
  logic [1:0]  dbg_wr_state;
  logic [1:0]  dbg_rd_state;
  logic        dbg_pwm_dir;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  breath_led_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .PWM_PERIOD         (PERIOD),
    .STEP_W             (16)
  ) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .led_o         (led),
    .dbg_wr_state  (dbg_wr_state),
    .dbg_rd_state  (dbg_rd_state),
    .dbg_pwm_dir   (dbg_pwm_dir)
  );

  // driver: full write transaction; resp is X on timeout
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awprot = 3'($urandom_range(0, 7));
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx; return; end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin resp = 2'bxx; return; end
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // driver: full read transaction; data/resp are X on timeout
  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr;
    arprot = 3'($urandom_range(0, 7));
    arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin arvalid = 1'b0; data = 'x; resp = 2'bxx; return; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin data = 'x; resp = 2'bxx; return; end
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, led} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {awready, wready, bvalid, arready, rvalid, led});
    end
    checks++;
    if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
      errors++; $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      checks++;
      if (d !== 32'h0 || r !== AXI_RESP_OKAY) begin
        errors++; $display("FAIL reset_reg%0d: got %h/%b want 00000000/00", i, d, r);
      end
    end
  endtask

  task automatic test_basic_rw();
    logic [31:0] d, e;
    logic [1:0]  r;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, r);
      exp_q.push_back(32'(i + 1));
      checks++;
      if (r !== AXI_RESP_OKAY) begin
        errors++; $display("FAIL basic_bresp%0d: got %b want 00", i, r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r);
      e = exp_q.pop_front();
      checks++;
      if (d !== e || r !== AXI_RESP_OKAY) begin
        errors++; $display("FAIL basic_read%0d: got %h/%b want %h/00", i, d, r, e);
      end
    end
    axi_write(4'h0, 32'h0, 4'hF, r);
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(4'h8, 32'h0, 4'hF, r);
    axi_write(4'h8, 32'hAABBCCDD, 4'b0101, r);
    axi_read(4'h8, d, r);
    checks++;
    if (d !== 32'h00BB00DD) begin
      errors++; $display("FAIL strobe_0101: got %h want 00bb00dd", d);
    end
    axi_write(4'hC, 32'h11223344, 4'hF, r);
    axi_write(4'hC, 32'hAABBCCDD, 4'b1000, r);
    axi_read(4'hC, d, r);
    checks++;
    if (d !== 32'hAA223344) begin
      errors++; $display("FAIL strobe_1000: got %h want aa223344", d);
    end
    // low address bits are ignored: 0x7 selects the STEP word
    axi_write(4'h7, 32'h12345678, 4'hF, r);
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h12345678) begin
      errors++; $display("FAIL addr_lowbits: got %h want 12345678", d);
    end
    axi_write(4'h4, 32'h0, 4'hF, r);
  endtask

  task automatic test_aw_early_bstall();
    logic [31:0] d;
    logic [1:0]  r;
    int early_rdy, pulses, mism, stall_drop;
    logic seen;
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b0;
    early_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (awready !== 1'b0 || wready !== 1'b0) early_rdy++;
    end
    checks++;
    if (early_rdy != 0) begin
      errors++; $display("FAIL aw_early_ready: got %0d ready cycles want 0", early_rdy);
    end
    wvalid = 1'b1;
    pulses = 0; mism = 0; seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (awready !== wready) mism++;
      if (awready === 1'b1) pulses++;
      if (seen) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (awready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (pulses != 1 || mism != 0) begin
      errors++; $display("FAIL aw_w_pulse: got pulses=%0d split=%0d want 1/0", pulses, mism);
    end
    stall_drop = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1) stall_drop++;
      @(negedge clk);
    end
    checks++;
    if (stall_drop != 0 || bresp !== AXI_RESP_OKAY) begin
      errors++; $display("FAIL bvalid_stall: got %0d low cycles bresp=%b want 0/00", stall_drop, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL bvalid_release: got %b want 0", bvalid);
    end
    axi_read(4'hC, d, r);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL aw_early_data: got %h want cafef00d", d);
    end
  endtask

  task automatic test_pwm_ramp();
    logic [1:0] r;
    int n, hi;
    int exp_hi [9];
    exp_hi = '{250, 500, 750, 1000, 750, 500, 250, 0, 250};
    axi_write(4'h4, 32'd250, 4'hF, r);
    axi_write(4'h0, 32'd1, 4'hF, r);
    n = 0;
    while (led !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n < 980 || n > 1010) begin
      errors++; $display("FAIL pwm_first_rise: got %0d cycles want 980..1010", n);
    end
    for (int w = 0; w < 9; w++) begin
      hi = 0;
      for (int c = 0; c < PERIOD; c++) begin
        if (led === 1'b1) hi++;
        @(negedge clk);
      end
      checks++;
      if (hi != exp_hi[w]) begin
        errors++; $display("FAIL pwm_frame%0d: got high=%0d want %0d", w, hi, exp_hi[w]);
      end
    end
  endtask

  task automatic test_disable_reenable();
    logic [1:0] r;
    int n, hi;
    // start of a duty-500 frame, so the LED is on right now
    checks++;
    if (led !== 1'b1) begin
      errors++; $display("FAIL pre_disable_led: got %b want 1", led);
    end
    axi_write(4'h0, 32'd0, 4'hF, r);
    checks++;
    if (led !== 1'b0) begin
      errors++; $display("FAIL disable_led: got %b want 0", led);
    end
    hi = 0;
    for (int c = 0; c < 1200; c++) begin
      if (led === 1'b1) hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 0) begin
      errors++; $display("FAIL disabled_quiet: got high=%0d want 0", hi);
    end
    axi_write(4'h0, 32'd1, 4'hF, r);
    n = 0;
    while (led !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n < 980 || n > 1010) begin
      errors++; $display("FAIL reenable_rise: got %0d cycles want 980..1010", n);
    end
    hi = 0;
    for (int c = 0; c < PERIOD; c++) begin
      if (led === 1'b1) hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 250) begin
      errors++; $display("FAIL reenable_frame1: got high=%0d want 250", hi);
    end
  endtask

  task automatic test_reset_midread();
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    axi_write(4'h8, 32'h00000055, 4'hF, r);
    @(negedge clk);
    araddr = 4'h8; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h55) begin
      errors++; $display("FAIL pending_read: got rvalid=%b rdata=%h want 1/00000055", rvalid, rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, arready, bvalid, led} !== 4'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset: got rvalid/arready/bvalid/led=%b rdata=%h want 0000/0",
                         {rvalid, arready, bvalid, led}, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(4'h0, d, r);
    checks++;
    if (d !== 32'h0 || r !== AXI_RESP_OKAY) begin
      errors++; $display("FAIL post_reset_ctrl: got %h/%b want 00000000/00", d, r);
    end
    axi_read(4'h8, d, r);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL post_reset_scr0: got %h want 00000000", d);
    end
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_rw();
    test_strobe();
    test_aw_early_bstall();
    test_pwm_ramp();
    test_disable_reenable();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
